// File: rtl/arbiter_wrr_if.sv
// Request/grant bundle between requesters and the weighted round-robin arbiter.
// The per-port lock vector exists only when ARBITER_WRR_LOCK_EN is defined.
interface arbiter_wrr_if #(
    parameter int NUM_PORTS    = 6,
    parameter int WEIGHT_WIDTH = 4
);
    localparam int ID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]              request;
    logic [NUM_PORTS*WEIGHT_WIDTH-1:0] weight;
`ifdef ARBITER_WRR_LOCK_EN
    logic [NUM_PORTS-1:0]              lock;
`endif
    logic [NUM_PORTS-1:0]              grant;
    logic [ID_W-1:0]                   grant_id;
    logic                              active;

`ifdef ARBITER_WRR_LOCK_EN
    modport master (
        output request, weight, lock,
        input  grant, grant_id, active
    );
    modport slave (
        input  request, weight, lock,
        output grant, grant_id, active
    );
`else
    modport master (
        output request, weight,
        input  grant, grant_id, active
    );
    modport slave (
        input  request, weight,
        output grant, grant_id, active
    );
`endif
endinterface

// File: rtl/arbiter_wrr.sv
// Look-ahead weighted round-robin arbiter: owners keep the grant for up to
// their weight in cycles, handover has no bubble. Optional lock: ARBITER_WRR_LOCK_EN.
//
//   state | meaning
//   ------+-------------------------------------------------
//   IDLE  | no owner, grant = 0; next edge grants any requester
//   OWN   | one owner (grant_id_q); holds while credit/lock allow
module arbiter_wrr #(
    parameter int NUM_PORTS    = 6,
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    arbiter_wrr_if.slave bus
);
    localparam int ID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_PORTS-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]         grant_id_q, grant_id_d;
    logic                    active_q, active_d;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

    logic [ID_W-1:0]         owner_d;
    logic [ID_W-1:0]         cand;
    logic [ID_W-1:0]         sel;
    logic                    found;
    logic [WEIGHT_WIDTH-1:0] sel_weight;
    logic [WEIGHT_WIDTH-1:0] load_credit;
    logic                    owner_req;
    logic                    owner_lock;
    logic                    hold;

    // Rotating search ptr+1 .. ptr; the current owner (== ptr) is looked at last.
    always_comb begin
        cand  = '0;
        found = 1'b0;
        sel   = ptr_q;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = ID_W'((int'(ptr_q) + i) % NUM_PORTS);
            if (!found && bus.request[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        sel_weight = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (sel == ID_W'(p)) begin
                sel_weight = bus.weight[p*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
        end
        load_credit = (sel_weight == '0) ? WEIGHT_WIDTH'(1) : sel_weight;
    end

    always_comb begin
        owner_req = bus.request[grant_id_q];
`ifdef ARBITER_WRR_LOCK_EN
        owner_lock = bus.lock[grant_id_q];
`else
        owner_lock = 1'b0;
`endif
        hold = (state_q == OWN) && owner_req &&
               ((credit_q > WEIGHT_WIDTH'(1)) || owner_lock);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            active_q   <= 1'b0;
            ptr_q      <= ID_W'(NUM_PORTS - 1);
            credit_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            active_q   <= active_d;
            ptr_q      <= ptr_d;
            credit_q   <= credit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        owner_d  = grant_id_q;
        if (hold) begin
            // A locked owner rides at credit 1 until it lets go of lock.
            if (credit_q > WEIGHT_WIDTH'(1)) begin
                credit_d = credit_q - WEIGHT_WIDTH'(1);
            end
        end else if (found) begin
            state_d  = OWN;
            owner_d  = sel;
            ptr_d    = sel;
            credit_d = load_credit;
        end else begin
            state_d = IDLE;
            owner_d = '0;
        end
    end

    always_comb begin
        grant_d    = '0;
        grant_id_d = '0;
        active_d   = 1'b0;
        if (state_d == OWN) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (owner_d == ID_W'(p)) begin
                    grant_d[p] = 1'b1;
                end
            end
            grant_id_d = owner_d;
            active_d   = 1'b1;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.grant_id = grant_id_q;
    assign bus.active   = active_q;

endmodule

// File: tb/tb_arbiter_wrr.sv
// Bench for arbiter_wrr with 4 ports: directed test-plan scenarios plus random
// traffic against a cycle-count ownership model. Lock scenario under ARBITER_WRR_LOCK_EN.
module tb_arbiter_wrr;
    localparam int N  = 4;
    localparam int WW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    arbiter_wrr_if #(.NUM_PORTS(N), .WEIGHT_WIDTH(WW)) bus ();

    arbiter_wrr #(.NUM_PORTS(N), .WEIGHT_WIDTH(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Model: owner index (-1 idle), cycles already granted, effective weight, pointer.
    int m_owner;
    int m_used;
    int m_wt;
    int m_ptr;

    logic [N-1:0] exp_grant;
    logic [1:0]   exp_id;
    logic         exp_act;

    function automatic int eff_weight(int p);
        logic [WW-1:0] w;
        w = WW'(bus.weight >> (p * WW));
        return (w == '0) ? 1 : int'(w);
    endfunction

    function automatic bit req_bit(int p);
        return ((bus.request >> p) & 4'b0001) != 4'b0000;
    endfunction

    function automatic bit lock_bit(int p);
`ifdef ARBITER_WRR_LOCK_EN
        return ((bus.lock >> p) & 4'b0001) != 4'b0000;
`else
        return (p < 0);
`endif
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_used  = 0;
        m_wt    = 0;
        m_ptr   = N - 1;
    endtask

    task automatic model_step();
        bit hold;
        int k;
        hold = 1'b0;
        if (m_owner >= 0) begin
            hold = req_bit(m_owner) && ((m_used < m_wt) || lock_bit(m_owner));
        end
        if (hold) begin
            m_used++;
        end else begin
            m_owner = -1;
            for (int s = 1; s <= N; s++) begin
                k = (m_ptr + s) % N;
                if (m_owner < 0 && req_bit(k)) m_owner = k;
            end
            if (m_owner >= 0) begin
                m_ptr  = m_owner;
                m_used = 1;
                m_wt   = eff_weight(m_owner);
            end
        end
        exp_grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        exp_id    = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        exp_act   = (m_owner >= 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        logic [N-1:0] seq [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                   4'b0100, 4'b1000, 4'b1000, 4'b0001};
        int           ids [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        bus.request = '0;
        bus.weight  = '0;
`ifdef ARBITER_WRR_LOCK_EN
        bus.lock    = '0;
`endif
        model_reset();
        #1;
        if (bus.grant !== 4'b0000 || bus.grant_id !== 2'd0 || bus.active !== 1'b0) begin
            fails++;
            $display("FAIL reset_por: grant=%b id=%0d active=%b required 0000/0/0",
                     bus.grant, bus.grant_id, bus.active);
        end
        checks++;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        bus.request = 4'b1111;
        bus.weight  = {4'd2, 4'd2, 4'd2, 4'd2};
        repeat (3) tick();
        if (bus.grant !== 4'b0010 || bus.active !== 1'b1) begin
            fails++;
            $display("FAIL reset_pregrant: grant=%b active=%b required 0010/1", bus.grant, bus.active);
        end
        checks++;
        #2 rst = 1'b0;
        #1;
        if (bus.grant !== 4'b0000 || bus.grant_id !== 2'd0 || bus.active !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: grant=%b id=%0d active=%b required 0000/0/0",
                     bus.grant, bus.grant_id, bus.active);
        end
        checks++;
        model_reset();
        #1 rst = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (bus.grant !== seq[i] || bus.grant_id !== 2'(ids[i]) || bus.active !== 1'b1) begin
                fails++;
                $display("FAIL reset_seq[%0d]: grant=%b id=%0d active=%b required %b/%0d/1",
                         i, bus.grant, bus.grant_id, bus.active, seq[i], ids[i]);
            end
            checks++;
        end
    endtask

    task automatic test_single();
        bus.request = 4'b0100;
        bus.weight  = {4'd3, 4'd3, 4'd3, 4'd3};
        for (int i = 0; i < 9; i++) begin
            tick();
            if (bus.grant !== 4'b0100 || bus.grant_id !== 2'd2 || bus.active !== 1'b1) begin
                fails++;
                $display("FAIL single[%0d]: grant=%b id=%0d active=%b required 0100/2/1",
                         i, bus.grant, bus.grant_id, bus.active);
            end
            checks++;
        end
    endtask

    task automatic test_zero_weight();
        logic [N-1:0] exp;
        bus.request = 4'b0000;
        tick();
        if (bus.grant !== 4'b0000 || bus.active !== 1'b0) begin
            fails++;
            $display("FAIL zero_w_idle: grant=%b active=%b required 0000/0", bus.grant, bus.active);
        end
        checks++;
        bus.weight  = '0;
        bus.request = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = 4'b0001 << ((3 + i) % 4);
            if (bus.grant !== exp) begin
                fails++;
                $display("FAIL zero_w[%0d]: grant=%b required %b", i, bus.grant, exp);
            end
            checks++;
        end
    endtask

    task automatic test_early_release();
        bus.weight  = {4'd2, 4'd1, 4'd8, 4'd1};
        bus.request = 4'b0001;
        tick();
        if (bus.grant !== 4'b0001) begin
            fails++;
            $display("FAIL early_setup: grant=%b required 0001", bus.grant);
        end
        checks++;
        bus.request = 4'b1010;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (bus.grant !== 4'b0010 || bus.grant_id !== 2'd1) begin
                fails++;
                $display("FAIL early_own[%0d]: grant=%b id=%0d required 0010/1",
                         i, bus.grant, bus.grant_id);
            end
            checks++;
        end
        bus.request = 4'b1000;
        tick();
        if (bus.grant !== 4'b1000 || bus.grant_id !== 2'd3 || bus.active !== 1'b1) begin
            fails++;
            $display("FAIL early_release: grant=%b id=%0d active=%b required 1000/3/1",
                     bus.grant, bus.grant_id, bus.active);
        end
        checks++;
    endtask

    task automatic test_ptr_retention();
        bus.request = 4'b0100;
        tick();
        if (bus.grant !== 4'b0100) begin
            fails++;
            $display("FAIL ptr_setup: grant=%b required 0100", bus.grant);
        end
        checks++;
        bus.request = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.grant !== 4'b0000 || bus.active !== 1'b0 || bus.grant_id !== 2'd0) begin
                fails++;
                $display("FAIL ptr_idle[%0d]: grant=%b id=%0d active=%b required 0000/0/0",
                         i, bus.grant, bus.grant_id, bus.active);
            end
            checks++;
        end
        bus.request = 4'b0101;
        tick();
        if (bus.grant !== 4'b0001 || bus.grant_id !== 2'd0) begin
            fails++;
            $display("FAIL ptr_resume: grant=%b id=%0d required 0001/0", bus.grant, bus.grant_id);
        end
        checks++;
    endtask

`ifdef ARBITER_WRR_LOCK_EN
    task automatic test_lock();
        bus.request = 4'b0000;
        bus.lock    = 4'b0000;
        tick();
        bus.weight  = {4'd1, 4'd1, 4'd1, 4'd1};
        bus.request = 4'b0001;
        bus.lock    = 4'b0001;
        tick();
        bus.request = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.grant !== 4'b0001) begin
                fails++;
                $display("FAIL lock_hold[%0d]: grant=%b required 0001", i, bus.grant);
            end
            checks++;
        end
        bus.lock = 4'b0000;
        tick();
        if (bus.grant !== 4'b0010) begin
            fails++;
            $display("FAIL lock_release: grant=%b required 0010", bus.grant);
        end
        checks++;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) bus.request = N'($urandom);
            if ($urandom_range(0, 7) == 0) bus.weight  = (N*WW)'($urandom);
`ifdef ARBITER_WRR_LOCK_EN
            bus.lock = ($urandom_range(0, 2) == 0) ? N'($urandom) : 4'b0000;
`endif
            if ($urandom_range(0, 149) == 0) begin
                #2 rst = 1'b0;
                #1;
                if (bus.grant !== 4'b0000 || bus.active !== 1'b0 || bus.grant_id !== 2'd0) begin
                    fails++;
                    $display("FAIL rand_reset[%0d]: grant=%b id=%0d active=%b required 0000/0/0",
                             i, bus.grant, bus.grant_id, bus.active);
                end
                checks++;
                model_reset();
                #1 rst = 1'b1;
            end
            tick();
            if (bus.grant !== exp_grant || bus.grant_id !== exp_id || bus.active !== exp_act) begin
                fails++;
                $display("FAIL random[%0d]: req=%b grant=%b id=%0d active=%b required %b/%0d/%b",
                         i, bus.request, bus.grant, bus.grant_id, bus.active,
                         exp_grant, exp_id, exp_act);
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_weight();
        test_early_release();
        test_ptr_retention();
`ifdef ARBITER_WRR_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
